// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative HI/LO multiply/divide unit
// Purpose: op codes as decoded in EX, sequencer state encodings, default
//          operand width, and small op-class decode helpers.
// Ports:   none (package).
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step_core.sv
// rtl/muldiv_step_core.sv - one radix-2 shift-add / restoring shift-subtract step
// Purpose: purely combinational step over the {acc, quo} register pair.
//          Multiply: acc:quo is the 2W product accumulator, quo starts as the
//          multiplier and is consumed LSB-first. Divide: quo starts as the
//          dividend and fills with quotient bits; acc ends as the remainder.
// Ports:
//   is_div    in   1      1 = divide step, 0 = multiply step
//   acc       in   WIDTH  upper half of the working pair
//   quo       in   WIDTH  lower half of the working pair
//   operand   in   WIDTH  multiplicand / divisor (magnitude)
//   acc_next  out  WIDTH  updated upper half
//   quo_next  out  WIDTH  updated lower half
module muldiv_step_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, quo[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    quo_next = quo;
    if (!is_div) begin
      // Carry out of the add becomes the new accumulator MSB as the pair shifts right.
      if (quo[0]) begin
        acc_next = sum[WIDTH:1];
        quo_next = {sum[0], quo[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[WIDTH-1:1]};
        quo_next = {acc[0], quo[WIDTH-1:1]};
      end
    end else begin
      // Partial remainder is below the divisor, so the shifted value fits WIDTH+1
      // bits and diff[WIDTH] is a clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative HI/LO mul/div sequencer for the 5-stage pipeline
// Purpose: runs MULT/MULTU/DIV/DIVU one radix-2 step per cycle on operand
//          magnitudes, applies signs in a final FIX cycle, and owns HI/LO.
//          Optional macro MULDIV_DIVZERO_EN: divide-by-zero short-cuts to FIX
//          and raises a sticky div_zero flag.
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high
//   start      in   1      launch strobe from EX
//   op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      in   WIDTH  multiplicand / dividend
//   src_b      in   WIDTH  multiplier / divisor
//   flush      in   1      abort the in-flight op
//   mf_req     in   1      MFHI/MFLO in EX this cycle
//   busy       out  1      op in flight
//   stall_req  out  1      freeze upstream stages
//   done       out  1      one-cycle pulse in the cycle HI/LO get written
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
//   div_zero   out  1      (MULDIV_DIVZERO_EN only) last accepted op divided by 0
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIVZERO_EN
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] lo
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_e           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_q, quo_q, operand_q;
  logic [WIDTH-1:0] acc_next, quo_next;
  logic             is_div_q, neg_lo_q, neg_hi_q;

  logic             accept;
  logic             dz_launch;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  assign accept = (state == ST_IDLE) && start && !flush;
  assign sign_a = op_is_signed(op) && src_a[WIDTH-1];
  assign sign_b = op_is_signed(op) && src_b[WIDTH-1];
  // INT_MIN maps to itself, which is the correct unsigned magnitude 2^(W-1).
  assign abs_a  = sign_a ? -src_a : src_a;
  assign abs_b  = sign_b ? -src_b : src_b;

`ifdef MULDIV_DIVZERO_EN
  assign dz_launch = op_is_div(op) && (src_b == '0);
`else
  assign dz_launch = 1'b0;
`endif

  muldiv_step_core #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .quo      (quo_q),
    .operand  (operand_q),
    .acc_next (acc_next),
    .quo_next (quo_next)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = dz_launch ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        if (flush)             state_next = ST_IDLE;
        else if (count == '0)  state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != ST_IDLE);
    stall_req = busy && (start || mf_req);
    done      = (state == ST_FIX) && !flush;
  end

  // Sign fix-up applied on the way into HI/LO.
  always_comb begin
    prod_fix = neg_lo_q ? -{acc_q, quo_q} : {acc_q, quo_q};
    if (is_div_q) begin
      lo_fix = neg_lo_q ? -quo_q : quo_q;
      hi_fix = neg_hi_q ? -acc_q : acc_q;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath: working registers, counter, HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            count <= CW'(WIDTH - 1);
            if (dz_launch) begin
              // Pre-load the divide-by-zero result so FIX writes it unchanged.
              acc_q     <= src_a;
              quo_q     <= '1;
              operand_q <= '0;
              is_div_q  <= 1'b1;
              neg_lo_q  <= 1'b0;
              neg_hi_q  <= 1'b0;
            end else begin
              acc_q     <= '0;
              quo_q     <= abs_a;
              operand_q <= abs_b;
              is_div_q  <= op_is_div(op);
              neg_lo_q  <= sign_a ^ sign_b;
              neg_hi_q  <= sign_a;
            end
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc_q <= acc_next;
            quo_q <= quo_next;
            count <= count - CW'(1);
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_zero <= 1'b0;
    else if (accept) div_zero <= dz_launch;
  end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          flush = 1'b0;
  logic          mf_req = 1'b0;
  logic          busy, stall_req, done;
  logic [W-1:0]  hi, lo;
`ifdef MULDIV_DIVZERO_EN
  logic          div_zero;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .mf_req    (mf_req),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
`ifdef MULDIV_DIVZERO_EN
    .lo        (lo),
    .div_zero  (div_zero)
`else
    .lo        (lo)
`endif
  );

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub, uq, urm;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      default: begin uq = ua / ub; urm = ua % ub; r = {urm[31:0], uq[31:0]}; end
    endcase
    return r;
  endfunction

  // Launch one op at cycle 0 and observe cycles 1..lat+1. poke_at re-asserts start
  // with different operands while busy; mf_from holds mf_req from that cycle on.
  task automatic exec_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int poke_at, input int mf_from,
                         output int done_at, output int done_n, output int busy_bad,
                         output int stall_bad, output int moved);
    logic [31:0] ph, pl;
    logic        eb, es;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    ph = hi; pl = lo;
    done_at = -1; done_n = 0; busy_bad = 0; stall_bad = 0; moved = 0;
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      start = (i == poke_at);
      if (i == poke_at) begin op = ~o; src_a = ~a; src_b = b ^ 32'h0000_0005; end
      mf_req = (mf_from > 0) && (i >= mf_from);
      #1;
      eb = (i <= lat);
      es = eb && (start || mf_req);
      if (busy !== eb) busy_bad++;
      if (stall_req !== es) stall_bad++;
      if (done === 1'b1) begin done_n++; if (done_at < 0) done_at = i; end
      if (i <= lat && (hi !== ph || lo !== pl)) moved++;
    end
    start = 1'b0; mf_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
`ifdef MULDIV_DIVZERO_EN
    checks++; if (div_zero !== 1'b0)  begin failures++; $display("FAIL reset_divzero got=%b exp=0", div_zero); end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, ehi, elo;
    int          mf, poke;
  } dcase_t;

  task automatic test_directed;
    dcase_t tbl[5];
    int da, dn, bb, sb, mv;
    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0};
    tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 0};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0};
    tbl[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0};
    tbl[4] = '{2'b11, 32'h7FFF_FFFF, 32'h0000_0003, 32'h0000_0001, 32'h2AAA_AAAA, 0, 7};
    foreach (tbl[k]) begin
      exec_op(tbl[k].o, tbl[k].a, tbl[k].b, LAT, tbl[k].poke, tbl[k].mf, da, dn, bb, sb, mv);
      checks++; if (da !== LAT) begin failures++; $display("FAIL dir%0d_done_cycle got=%0d exp=%0d", k, da, LAT); end
      checks++; if (dn !== 1)   begin failures++; $display("FAIL dir%0d_done_pulses got=%0d exp=1", k, dn); end
      checks++; if (bb !== 0)   begin failures++; $display("FAIL dir%0d_busy_cycles bad=%0d exp=0", k, bb); end
      checks++; if (sb !== 0)   begin failures++; $display("FAIL dir%0d_stall_cycles bad=%0d exp=0", k, sb); end
      checks++; if (mv !== 0)   begin failures++; $display("FAIL dir%0d_hilo_early bad=%0d exp=0", k, mv); end
      checks++; if (hi !== tbl[k].ehi || lo !== tbl[k].elo)
        begin failures++; $display("FAIL dir%0d_result got=%h_%h exp=%h_%h", k, hi, lo, tbl[k].ehi, tbl[k].elo); end
    end
  endtask

  task automatic test_divzero;
    int da, dn, bb, sb, mv, lat;
`ifdef MULDIV_DIVZERO_EN
    lat = 1;
`else
    lat = LAT;
`endif
    exec_op(2'b11, 32'd5, 32'd0, lat, 0, 0, da, dn, bb, sb, mv);
    checks++; if (da !== lat) begin failures++; $display("FAIL dz_done_cycle got=%0d exp=%0d", da, lat); end
    checks++; if (dn !== 1 || bb !== 0) begin failures++; $display("FAIL dz_done_busy pulses=%0d busybad=%0d exp=1,0", dn, bb); end
    checks++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF)
      begin failures++; $display("FAIL dz_result got=%h_%h exp=00000005_ffffffff", hi, lo); end
`ifdef MULDIV_DIVZERO_EN
    checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
    exec_op(2'b11, 32'd10, 32'd3, LAT, 0, 0, da, dn, bb, sb, mv);
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL dz_flag_clear got=%b exp=0", div_zero); end
    checks++; if (hi !== 32'd1 || lo !== 32'd3) begin failures++; $display("FAIL dz_after got=%h_%h exp=1_3", hi, lo); end
`endif
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp_r;
    int da, dn, bb, sb, mv, poke, mf;
    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      if (o[1] && b == 32'd0) b = 32'd1;
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32)) : 0;
      mf   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 33)) : 0;
      exp_r = model(o, a, b);
      exec_op(o, a, b, LAT, poke, mf, da, dn, bb, sb, mv);
      checks++; if (da !== LAT || dn !== 1)
        begin failures++; $display("FAIL rnd%0d_done at=%0d pulses=%0d exp=%0d,1", n, da, dn, LAT); end
      checks++; if (bb !== 0 || sb !== 0 || mv !== 0)
        begin failures++; $display("FAIL rnd%0d_ctrl busybad=%0d stallbad=%0d early=%0d exp=0", n, bb, sb, mv); end
      checks++; if ({hi, lo} !== exp_r)
        begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h exp=%h", n, o, a, b, hi, lo, exp_r); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] ph, pl;
    int bad, dn, mv;
    // Flush mid-RUN
    @(negedge clk);
    op = 2'b01; src_a = $urandom; src_b = $urandom; start = 1'b1;
    ph = hi; pl = lo; bad = 0; dn = 0; mv = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0; flush = (i == 10);
      #1;
      if (busy !== (i <= 10)) bad++;
      if (done === 1'b1) dn++;
      if (hi !== ph || lo !== pl) mv++;
    end
    flush = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL flush_run_busy bad=%0d exp=0", bad); end
    checks++; if (dn !== 0 || mv !== 0) begin failures++; $display("FAIL flush_run_effect done=%0d moved=%0d exp=0,0", dn, mv); end
    // Flush during FIX
    @(negedge clk);
    op = 2'b00; src_a = 32'h0000_1234; src_b = 32'h0000_0011; start = 1'b1;
    ph = hi; pl = lo; bad = 0; dn = 0; mv = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      start = 1'b0; flush = (i == LAT);
      #1;
      if (busy !== (i <= LAT)) bad++;
      if (done === 1'b1) dn++;
      if (hi !== ph || lo !== pl) mv++;
    end
    flush = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL flush_fix_busy bad=%0d exp=0", bad); end
    checks++; if (dn !== 0 || mv !== 0) begin failures++; $display("FAIL flush_fix_effect done=%0d moved=%0d exp=0,0", dn, mv); end
    // Start and flush together in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle busy=%b exp=0", busy); end
    // mf_req alone in IDLE
    mf_req = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mf_idle_stall got=%b exp=0", stall_req); end
    mf_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    int da, dn, bb, sb, mv;
    exec_op(2'b01, 32'd3, 32'd5, LAT, 0, 0, da, dn, bb, sb, mv);
    checks++; if (lo !== 32'd15) begin failures++; $display("FAIL pre_reset_lo got=%h exp=0000000f", lo); end
    @(negedge clk);
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL reset_mid_ctrl busy=%b done=%b exp=0,0", busy, done); end
    checks++; if (hi !== '0 || lo !== '0)
      begin failures++; $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    exec_op(2'b10, 32'd100, 32'd7, LAT, 0, 0, da, dn, bb, sb, mv);
    checks++; if (hi !== 32'd2 || lo !== 32'd14 || da !== LAT)
      begin failures++; $display("FAIL post_reset_div got=%h_%h at=%0d exp=2_e at %0d", hi, lo, da, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_random();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
